// File: rtl/regfile_dump_reader.sv
// Walks R0..R(NUM_REGS-1) through a spare registered read port and emits each
// value on a valid/ready stream tagged with its index and a last flag.
module regfile_dump_reader #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [IDX_W-1:0]  rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [IDX_W-1:0]  dump_idx,
   output logic              dump_last
);

   typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, FIN} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             hs;

   assign hs = dump_valid & dump_ready;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      rd_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               idx_nxt   = '0;
               state_nxt = READ;
            end
         end
         READ: begin
            rd_en     = 1'b1;
            busy      = 1'b1;
            state_nxt = CAPT;
         end
         CAPT: begin
            busy      = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            busy = 1'b1;
            if (hs) begin
               if (dump_last) begin
                  state_nxt = FIN;
               end else begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = READ;
               end
            end
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Address is loaded on entry to READ so it equals idx there and holds afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr <= '0;
      end else if (state_nxt == READ) begin
         rd_addr <= idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dump_valid <= 1'b0;
         dump_data  <= '0;
         dump_idx   <= '0;
         dump_last  <= 1'b0;
      end else if (state == CAPT) begin
         dump_valid <= 1'b1;
         dump_data  <= rd_data;
         dump_idx   <= idx;
         dump_last  <= (idx == LAST_IDX);
      end else if (state == SEND && hs) begin
         dump_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a register-file model feeds the read port and a
// queue-style expectation (one word per register, in order) checks the stream.
module tb_regfile_dump_reader;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int IDX_W    = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              dump_ready = 1'b0;
   logic              busy, done, rd_en, dump_valid, dump_last;
   logic [IDX_W-1:0]  rd_addr, dump_idx;
   logic [DATA_W-1:0] rd_data, dump_data;

   logic              we = 1'b0;
   logic [IDX_W-1:0]  wa = '0;
   logic [DATA_W-1:0] wd = '0;
   logic [DATA_W-1:0] regs    [NUM_REGS];
   logic [DATA_W-1:0] exp_mem [NUM_REGS];

   int checks = 0;
   int passes = 0;

   typedef struct {
      int pct;
      int mode;
      int stall_idx;
      int stall_len;
      int busy_idx;
      int exp_words;
      int exp_dones;
      int exp_reads;
      int exp_first;
      int exp_last;
   } vec_t;

   always #5 clk = ~clk;

   regfile_dump_reader #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
      .dump_idx(dump_idx), .dump_last(dump_last)
   );

   // Register file: CPU write port plus a one-cycle registered read port.
   always @(posedge clk) begin
      if (we) regs[wa] <= wd;
      if (rd_en) rd_data <= regs[rd_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic load(input int mode);
      logic [DATA_W-1:0] v;
      for (int k = 0; k < NUM_REGS; k++) begin
         case (mode)
            0:       v = DATA_W'(k * 3 + 7);
            1:       v = ~DATA_W'(k);
            2:       v = $urandom;
            default: v = (k == 4) ? 32'hDEADBEEF : DATA_W'(k * 3 + 7);
         endcase
         exp_mem[k] = v;
         we = 1'b1; wa = IDX_W'(k); wd = v;
         tick;
      end
      we = 1'b0;
   endtask

   task automatic run_dump(input int pct, input int stall_idx, input int stall_len,
                           input int busy_idx, output int words, output int dones,
                           output int reads, output int first_lat, output int last_cyc);
      int c, stall_left, exp_k, exp_rd, post;
      bit stall_done, bs_done, hold_prev, finished;
      logic [DATA_W-1:0] pd;
      logic [IDX_W-1:0]  pi;
      words = 0; dones = 0; reads = 0; first_lat = -1; last_cyc = -1;
      c = 0; stall_left = 0; exp_k = 0; exp_rd = 0; post = 0;
      stall_done = 0; bs_done = 0; hold_prev = 0; finished = 0;
      pd = '0; pi = '0;
      check("idle_before_start", 64'(busy), 64'(0));
      start = 1'b1;
      while (!finished && c < 3000) begin
         if (c > 0) start = 1'b0;
         if (dump_valid && first_lat < 0) first_lat = c;
         if (hold_prev) begin
            check("stall_valid", 64'(dump_valid), 64'(1));
            check("stall_data", 64'(dump_data), 64'(pd));
            check("stall_idx", 64'(dump_idx), 64'(pi));
         end
         check("no_read_in_send", 64'(rd_en & dump_valid), 64'(0));
         if (rd_en) begin
            check("rd_addr", 64'(rd_addr), 64'(exp_rd));
            exp_rd++;
            reads++;
         end
         if (stall_left > 0) begin
            dump_ready = 1'b0;
            stall_left--;
         end else if (dump_valid && stall_len > 0 && !stall_done && int'(dump_idx) == stall_idx) begin
            dump_ready = 1'b0;
            stall_left = stall_len - 1;
            stall_done = 1'b1;
         end else begin
            dump_ready = (int'($urandom_range(99)) < pct);
         end
         hold_prev = dump_valid && !dump_ready;
         pd = dump_data;
         pi = dump_idx;
         if (dump_valid && dump_ready) begin
            if (exp_k < NUM_REGS) begin
               check("hs_idx", 64'(dump_idx), 64'(exp_k));
               check("hs_data", 64'(dump_data), 64'(exp_mem[exp_k]));
               check("hs_last", 64'(dump_last), 64'(exp_k == NUM_REGS - 1));
            end else begin
               check("extra_word", 64'(exp_k), 64'(NUM_REGS - 1));
            end
            if (exp_k == NUM_REGS - 1) last_cyc = c;
            exp_k++;
            words++;
         end
         if (busy_idx >= 0 && !bs_done && dump_valid && int'(dump_idx) == busy_idx) begin
            start = 1'b1;
            bs_done = 1'b1;
            check("busy_at_start", 64'(busy), 64'(1));
         end
         if (done) begin
            dones++;
            check("done_timing", 64'(c), 64'(last_cyc + 1));
            check("busy_in_fin", 64'(busy), 64'(0));
         end
         if (dones > 0) begin
            post++;
            if (post > 4) finished = 1'b1;
         end
         tick;
         c++;
      end
      start = 1'b0;
      dump_ready = 1'b0;
      check("dump_timeout", 64'(finished), 64'(1));
      check("idle_after", 64'(busy), 64'(0));
   endtask

   initial begin
      vec_t tv[5];
      int words, dones, reads, first_lat, last_cyc, c;
      bit found, got, finished;

      // pct, mode, stall_idx, stall_len, busy_idx, words, dones, reads, first, last
      tv[0] = '{100, 0, -1, 0,  -1, 32, 1, 32, 3, 96};
      tv[1] = '{100, 3,  4, 10, -1, 32, 1, 32, 3, 106};
      tv[2] = '{100, 0, -1, 0,  12, 32, 1, 32, 3, 96};
      tv[3] = '{50,  1, -1, 0,  -1, 32, 1, 32, 3, 0};
      tv[4] = '{30,  2, -1, 0,  -1, 32, 1, 32, 3, 0};

      tick; tick;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_rd_en", 64'(rd_en), 64'(0));
      check("rst_valid", 64'(dump_valid), 64'(0));
      check("rst_last", 64'(dump_last), 64'(0));
      check("rst_rd_addr", 64'(rd_addr), 64'(0));
      check("rst_data", 64'(dump_data), 64'(0));
      check("rst_idx", 64'(dump_idx), 64'(0));
      reset = 1'b1;
      tick;

      for (int i = 0; i < 5; i++) begin
         load(tv[i].mode);
         run_dump(tv[i].pct, tv[i].stall_idx, tv[i].stall_len, tv[i].busy_idx,
                  words, dones, reads, first_lat, last_cyc);
         check($sformatf("v%0d_words", i), 64'(words), 64'(tv[i].exp_words));
         check($sformatf("v%0d_dones", i), 64'(dones), 64'(tv[i].exp_dones));
         check($sformatf("v%0d_reads", i), 64'(reads), 64'(tv[i].exp_reads));
         check($sformatf("v%0d_first", i), 64'(first_lat), 64'(tv[i].exp_first));
         if (tv[i].exp_last > 0)
            check($sformatf("v%0d_last_cyc", i), 64'(last_cyc), 64'(tv[i].exp_last));
      end

      // Reset while word 20 is waiting in SEND.
      load(0);
      start = 1'b1; dump_ready = 1'b1; c = 0; found = 1'b0;
      while (c < 500 && !found) begin
         if (c > 0) start = 1'b0;
         if (dump_valid && dump_idx == 5'd20) found = 1'b1;
         else begin tick; c++; end
      end
      start = 1'b0;
      check("rst_reach20", 64'(found), 64'(1));
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(dump_valid), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_rd_en", 64'(rd_en), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      dones = 0;
      repeat (3) begin tick; if (done) dones++; end
      reset = 1'b1;
      tick;
      if (done) dones++;
      check("mid_rst_no_done", 64'(dones), 64'(0));
      start = 1'b1;
      tick;
      start = 1'b0;
      c = 1;
      while (c < 50 && !dump_valid) begin tick; c++; end
      check("restart_lat", 64'(c), 64'(3));
      check("restart_idx", 64'(dump_idx), 64'(0));
      check("restart_data", 64'(dump_data), 64'(exp_mem[0]));
      reset = 1'b0; tick; reset = 1'b1; tick;

      // CPU writes R10 around its dump read; word 10 must carry the READ-cycle value.
      load(0);
      start = 1'b1; dump_ready = 1'b1; c = 0; got = 1'b0; finished = 1'b0;
      while (c < 500 && !finished) begin
         if (c > 0) start = 1'b0;
         we = 1'b0;
         if (rd_en && rd_addr == 5'd9) begin
            we = 1'b1; wa = 5'd10; wd = 32'd55;
         end
         if (dump_valid && dump_idx == 5'd10 && !got) begin
            we = 1'b1; wa = 5'd10; wd = 32'd99;
            check("live_r10", 64'(dump_data), 64'(55));
            got = 1'b1;
         end
         if (done) finished = 1'b1;
         tick;
         c++;
      end
      we = 1'b0;
      start = 1'b0;
      check("live_seen", 64'(got), 64'(1));
      check("live_done", 64'(finished), 64'(1));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug-side reader for the CPU register file: on a single start pulse it walks R0..R(NUM_REGS-1) through a dedicated registered read port.
- Each value goes out on a valid/ready stream tagged with its index and a last flag.
- Replaces hierarchical register peeking in benches and feeds a debug/trace sink in silicon.
- Sits beside the CPU core and is attached to the register file's spare read port.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of registers dumped, indices 0..NUM_REGS-1
IDX_W, 5, index width; must satisfy 2**IDX_W >= NUM_REGS

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a dump; ignored while busy=1
busy  output  1  high from the cycle after an accepted start through the final handshake
done  output  1  one-cycle pulse the cycle after the last word's handshake
rd_en  output  1  register file read strobe
rd_addr  output  IDX_W  register file read address
rd_data  input  DATA_W  read data, valid exactly one cycle after rd_en
dump_valid  output  1  stream word valid
dump_ready  input  1  sink accepts the word when high with dump_valid
dump_data  output  DATA_W  register value
dump_idx  output  IDX_W  register index of dump_data
dump_last  output  1  high with the word for index NUM_REGS-1

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy, done, rd_en, dump_valid and dump_last are 0.
  - rd_addr, dump_data, dump_idx and the internal index counter are 0.
  - Reset may assert at any point mid-dump. The dump is abandoned with no done pulse, and the next start after release begins again at index 0.
- FSM states: IDLE, READ, CAPT, SEND, FIN.
  - IDLE: on start=1, idx<=0, go to READ. busy rises in the following cycle.
  - READ: rd_en=1 and rd_addr=idx for exactly this one cycle; go to CAPT.
  - CAPT:
    - rd_data is valid this cycle and is registered into dump_data at the clock edge ending CAPT.
    - At the same edge: dump_idx<=idx, dump_last<=(idx==NUM_REGS-1), dump_valid<=1. Go to SEND.
  - SEND:
    - dump_valid=1.
    - dump_data, dump_idx and dump_last stay stable until the handshake (dump_valid & dump_ready).
    - On handshake: dump_valid<=0. If dump_last then go to FIN, else idx<=idx+1 and go to READ.
    - No handshake: remain in SEND indefinitely; no backpressure timeout.
  - FIN: done=1 for this one cycle, busy=0; go to IDLE. Any start seen in FIN is ignored.
- rd_en is 0 in every state except READ. rd_addr holds its last value outside READ.
- Latency and throughput:
  - The first word is valid 3 cycles after the start cycle (start, READ, CAPT, then SEND).
  - With dump_ready held high, one word completes every 3 cycles.
  - A full dump of 32 registers takes 96 cycles from start to the last handshake; done follows the next cycle.
- Indexing: the index counter is IDX_W bits and never wraps, because the dump ends at NUM_REGS-1. If NUM_REGS < 2**IDX_W, the unused addresses are never issued.
- Data is passed through unmodified. No arithmetic is applied to rd_data.
- dump_ready is ignored whenever dump_valid=0.
- A start coinciding with the last handshake is ignored, since busy is still 1.
- Register file writes by the CPU during a dump are not blocked. Each word reflects the register's value in its own READ cycle.

Test Plan:
- Basic dump: preload R_k = k*3+7, hold dump_ready=1, pulse start.
  - Required: 32 words with idx 0..31 and data 7,10,...,100.
  - dump_last only on idx 31.
  - First dump_valid 3 cycles after start.
  - done exactly 1 cycle after the idx-31 handshake, then busy=0.
- Backpressure: dump_ready=0 for 10 cycles while word idx 4 (value 0xDEADBEEF) is valid.
  - Required: dump_valid, data and idx stay stable all 10 cycles.
  - No rd_en is issued during the stall.
  - idx 5 is read only after the handshake.
- Start while busy: pulse start at word idx 12.
  - Required: ignored; the dump continues to idx 31 with exactly one done pulse.
  - Total handshakes equal 32.
- Reset mid-dump: assert reset=0 in SEND at idx 20.
  - Required: immediately dump_valid=0, busy=0, rd_en=0, with no done pulse.
  - After release, a new start produces idx 0 first.
- Random ready: dump_ready randomized at 50% with R_k = ~k.
  - Required: exactly 32 handshakes in index order with matching data.
  - No duplicate or skipped indices.
- Live write: the CPU writes R10 = 55 during the READ cycle for idx 9, then R10 = 99 during the SEND for idx 10.
  - Required: dumped R10 = 55.
